// File: rtl/ibex_mem_arbiter.sv
// rtl/ibex_mem_arbiter.sv - shares one memory port between Ibex fetch and data ports
// Optional: define ARB_ROUND_ROBIN_EN for round-robin contention (default fixed DATA priority).
module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [3:0]  outstanding_o,
    output logic        protocol_err_o
);

    localparam logic       SEL_INSTR = 1'b0;
    localparam logic       SEL_DATA  = 1'b1;
    localparam logic [2:0] LAST_IDX  = 3'(MaxOutstanding - 1);
    localparam logic [3:0] MAX_CNT   = 4'(MaxOutstanding);

    logic [3:0] count_q, count_d;
    logic [2:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0] id_q;
    logic       lock_q, lock_d;
    logic       lock_sel_q, lock_sel_d;
    logic       perr_q, perr_d;
    logic       sel, contend_sel, push, pop, head;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign contend_sel = (last_q == SEL_INSTR) ? SEL_DATA : SEL_INSTR;
    assign last_d      = push ? sel : last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= SEL_INSTR;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign contend_sel = SEL_DATA;
`endif

    // A pending ungranted request keeps its source so the address cannot move under the memory.
    always_comb begin
        sel = SEL_INSTR;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
            sel = contend_sel;
        end else if (data_req_i) begin
            sel = SEL_DATA;
        end
    end

    assign mem_req_o   = (instr_req_i | data_req_i) & (count_q < MAX_CNT) & ~rst_i;
    assign mem_addr_o  = (sel == SEL_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = (sel == SEL_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == SEL_DATA) ? data_be_i    : 4'hF;
    assign mem_wdata_o = (sel == SEL_DATA) ? data_wdata_i : 32'h0;

    assign push        = mem_req_o & mem_gnt_i;
    assign instr_gnt_o = push & (sel == SEL_INSTR);
    assign data_gnt_o  = push & (sel == SEL_DATA);

    assign pop            = mem_rvalid_i & (count_q != 4'd0) & ~rst_i;
    assign head           = id_q[rptr_q];
    assign instr_rvalid_o = pop & (head == SEL_INSTR);
    assign data_rvalid_o  = pop & (head == SEL_DATA);
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o  = count_q;
    assign protocol_err_o = perr_q;

    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        lock_d     = mem_req_o & ~mem_gnt_i;
        lock_sel_d = sel;
        perr_d     = perr_q | (mem_rvalid_i & (count_q == 4'd0));
        if (push) begin
            wptr_d = (wptr_q == LAST_IDX) ? 3'd0 : wptr_q + 3'd1;
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_IDX) ? 3'd0 : rptr_q + 3'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q    <= 4'd0;
            wptr_q     <= 3'd0;
            rptr_q     <= 3'd0;
            id_q       <= 8'd0;
            lock_q     <= 1'b0;
            lock_sel_q <= SEL_INSTR;
            perr_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            perr_q     <= perr_d;
            if (push) begin
                id_q[wptr_q] <= sel;
            end
        end
    end

endmodule
